// File: rtl/renkon_conv_window5x5.sv
// Streaming 5x5 neighbourhood generator: four line buffers plus a 5x5 shift window
// turn a raster pixel stream into 25-element vectors for the convolution tree.
module renkon_conv_window5x5 #(
  parameter int DWIDTH = 16,
  parameter int MAXW   = 32,
  parameter int SWIDTH = 6
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     start,
  input  logic [SWIDTH-1:0]        img_size,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] pixel_in,
  output logic                     win_valid,
  output logic signed [DWIDTH-1:0] window [25-1:0],
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_next;

  logic [SWIDTH-1:0]        size_q;
  logic [SWIDTH-1:0]        row;
  logic [SWIDTH-1:0]        col;
  logic [SWIDTH-1:0]        last_idx;
  logic [AW-1:0]            addr;
  logic                     accept;
  logic                     size_ok;
  logic                     start_ok;
  logic                     col_last;
  logic                     row_last;
  logic signed [DWIDTH-1:0] lb [4][MAXW];
  logic signed [DWIDTH-1:0] col_vec [5];

  assign last_idx = size_q - SWIDTH'(1);
  assign size_ok  = (img_size >= SWIDTH'(5)) && (img_size <= SWIDTH'(MAXW));
  assign start_ok = (state == IDLE) && start && size_ok;
  assign accept   = (state == RUN) && in_valid;
  assign col_last = (col == last_idx);
  assign row_last = (row == last_idx);
  assign addr     = col[AW-1:0];
  assign busy     = (state != IDLE);

  // Column vector entering the window: oldest row at the top, live pixel at the bottom.
  assign col_vec[0] = lb[0][addr];
  assign col_vec[1] = lb[1][addr];
  assign col_vec[2] = lb[2][addr];
  assign col_vec[3] = lb[3][addr];
  assign col_vec[4] = pixel_in;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (accept && col_last && row_last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      size_q    <= '0;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= (state == FIN);
      err       <= (state == IDLE) && start && !size_ok;
      win_valid <= accept && (row >= SWIDTH'(4)) && (col >= SWIDTH'(4));
      if (start_ok) begin
        size_q <= img_size;
        row    <= '0;
        col    <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row + SWIDTH'(1);
        end else begin
          col <= col + SWIDTH'(1);
        end
      end
    end
  end

  // Window shifts left one column per accepted pixel; new column enters at j=4.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int k = 0; k < 25; k++) window[k] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) window[5*i+j] <= window[5*i+j+1];
        window[5*i+4] <= col_vec[i];
      end
    end
  end

  // Line buffers are never read before being rewritten in the current plane, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][addr] <= lb[1][addr];
      lb[1][addr] <= lb[2][addr];
      lb[2][addr] <= lb[3][addr];
      lb[3][addr] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_renkon_conv_window5x5.sv
// Self-checking bench for renkon_conv_window5x5: a plane-level model stores every pixel
// by (row, col) and builds each expected 5x5 neighbourhood directly from that image.
module tb_renkon_conv_window5x5;

  localparam int DWIDTH = 16;
  localparam int MAXW   = 32;
  localparam int SWIDTH = 6;
  localparam int FW     = 25 * DWIDTH;

  logic                     clk = 1'b0;
  logic                     xrst;
  logic                     start;
  logic [SWIDTH-1:0]        img_size;
  logic                     in_valid;
  logic signed [DWIDTH-1:0] pixel_in;
  logic                     win_valid;
  logic signed [DWIDTH-1:0] window [25-1:0];
  logic                     busy;
  logic                     done;
  logic                     err;

  int checks = 0;
  int errors = 0;

  // Reference model state: plane in progress, pixels accepted so far, and the stored image.
  bit                       m_active;
  bit                       m_fin;
  int                       m_size;
  int                       m_n;
  logic signed [DWIDTH-1:0] img [MAXW][MAXW];
  logic                     exp_wv;
  logic                     exp_done;
  logic                     exp_err;
  logic [FW-1:0]            exp_win;
  int                       win_seen;

  always #5 clk = ~clk;

  renkon_conv_window5x5 #(.DWIDTH(DWIDTH), .MAXW(MAXW), .SWIDTH(SWIDTH)) dut (
    .clk(clk),
    .xrst(xrst),
    .start(start),
    .img_size(img_size),
    .in_valid(in_valid),
    .pixel_in(pixel_in),
    .win_valid(win_valid),
    .window(window),
    .busy(busy),
    .done(done),
    .err(err)
  );

  function automatic logic [FW-1:0] dutWindow();
    logic [FW-1:0] f;
    for (int k = 0; k < 25; k++) f[k*DWIDTH +: DWIDTH] = window[k];
    return f;
  endfunction

  function automatic logic [FW-1:0] rampWindow();
    logic [FW-1:0] f;
    for (int k = 0; k < 25; k++) f[k*DWIDTH +: DWIDTH] = DWIDTH'(k);
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, and advance the model by that cycle.
  task automatic applyStimulus(input logic s, input int sz, input logic v,
                               input logic signed [DWIDTH-1:0] px);
    int r;
    int c;
    start    = s;
    img_size = sz[SWIDTH-1:0];
    in_valid = v;
    pixel_in = px;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    exp_wv   = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (!m_active) begin
      if (s) begin
        if (sz >= 5 && sz <= MAXW) begin
          m_active = 1'b1;
          m_fin    = 1'b0;
          m_size   = sz;
          m_n      = 0;
        end else begin
          exp_err = 1'b1;
        end
      end
    end else if (m_fin) begin
      m_fin    = 1'b0;
      m_active = 1'b0;
      exp_done = 1'b1;
    end else if (v) begin
      r = m_n / m_size;
      c = m_n % m_size;
      img[r][c] = px;
      if (r >= 4 && c >= 4) begin
        exp_wv = 1'b1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            exp_win[(5*i+j)*DWIDTH +: DWIDTH] = img[r-4+i][c-4+j];
      end
      if (m_n == m_size * m_size - 1) m_fin = 1'b1;
      m_n++;
    end
  endtask

  task automatic checkCycle(input string tag);
    checkOutput({tag, " win_valid"}, FW'(win_valid), FW'(exp_wv));
    checkOutput({tag, " busy"},      FW'(busy),      FW'(m_active));
    checkOutput({tag, " done"},      FW'(done),      FW'(exp_done));
    checkOutput({tag, " err"},       FW'(err),       FW'(exp_err));
    if (win_valid) win_seen++;
    if (exp_wv) checkOutput({tag, " window"}, dutWindow(), exp_win);
  endtask

  task automatic runStep(input logic s, input int sz, input logic v,
                         input logic signed [DWIDTH-1:0] px, input string tag);
    applyStimulus(s, sz, v, px);
    checkCycle(tag);
  endtask

  // pmode: 0 ramp, 1 value 10*r+c, 2 random. gmode: 0 no gaps, 1 alternate, 2 random gaps.
  // intr_at: cycle index at which a start with size 6 is injected mid-plane (-1 = none).
  task automatic feedPlane(input string tag, input int sz, input int pmode, input int gmode,
                           input int intr_at);
    int n;
    int cyc;
    int r;
    int c;
    logic v;
    logic signed [DWIDTH-1:0] px;
    n = 0;
    cyc = 0;
    win_seen = 0;
    runStep(1'b1, sz, 1'b0, '0, tag);
    while (n < sz * sz) begin
      case (gmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      r = n / sz;
      c = n % sz;
      case (pmode)
        0:       px = DWIDTH'(n);
        1:       px = DWIDTH'(10 * r + c);
        default: px = DWIDTH'($urandom);
      endcase
      if (!v) px = DWIDTH'($urandom);
      runStep(cyc == intr_at, (cyc == intr_at) ? 6 : sz, v, px, tag);
      if (v) n++;
      cyc++;
    end
    runStep(1'b0, sz, 1'b0, '0, tag);
    runStep(1'b0, sz, 1'b0, '0, tag);
    checkOutput({tag, " window count"}, FW'(win_seen), FW'((sz - 4) * (sz - 4)));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " win_valid"}, FW'(win_valid), '0);
    checkOutput({tag, " busy"},      FW'(busy),      '0);
    checkOutput({tag, " done"},      FW'(done),      '0);
    checkOutput({tag, " err"},       FW'(err),       '0);
    checkOutput({tag, " window"},    dutWindow(),    '0);
  endtask

  initial begin
    xrst     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    img_size = '0;
    pixel_in = '0;
    m_active = 1'b0;
    m_fin    = 1'b0;
    m_size   = 0;
    m_n      = 0;

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    #2 xrst = 1'b1;

    feedPlane("ramp5", 5, 0, 0, -1);
    checkOutput("ramp5 held window", dutWindow(), rampWindow());

    feedPlane("grid8", 8, 1, 0, -1);
    feedPlane("grid8_stall", 8, 1, 1, -1);

    runStep(1'b1, 4, 1'b0, '0, "illegal4");
    for (int k = 0; k < 6; k++) runStep(1'b0, 4, 1'b1, DWIDTH'(k), "illegal4 px");
    runStep(1'b1, MAXW + 1, 1'b0, '0, "illegal33");
    for (int k = 0; k < 30; k++) runStep(1'b0, MAXW + 1, 1'b1, DWIDTH'($urandom), "illegal33 px");

    feedPlane("busy_start", 8, 1, 0, 20);
    feedPlane("rand", int'($urandom_range(5, 12)), 2, 2, -1);
    feedPlane("max", MAXW, 2, 2, -1);

    runStep(1'b1, 8, 1'b0, '0, "midreset");
    for (int k = 0; k < 30; k++)
      runStep(1'b0, 8, 1'b1, DWIDTH'(10 * (k / 8) + (k % 8)), "midreset px");
    #2 xrst = 1'b0;
    #1;
    checkAllZero("async reset");
    m_active = 1'b0;
    m_fin    = 1'b0;
    #2 xrst = 1'b1;

    feedPlane("ramp_after_reset", 5, 0, 0, -1);
    checkOutput("ramp_after_reset held window", dutWindow(), rampWindow());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/renkon_conv_window5x5.md
Name: renkon_conv_window5x5

Overview:
- Producer-side counterpart of the 25-tap convolution tree.
- Accepts a raster-order pixel stream of one square feature-map plane.
- Uses 4 line buffers plus a 5x5 shift window to emit every valid 5x5 neighbourhood as a 25-element vector.
- Output vector ordering matches the tree's `pixel[25]` input, so `window` connects to it directly.

Parameters:
- DWIDTH, 16, pixel data width (signed).
- MAXW, 32, maximum supported plane width/height.
- SWIDTH, 6, size/counter width; must satisfy 2^SWIDTH > MAXW.

Ports:
- clk  input  1  clock.
- xrst  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new plane.
- img_size  input  SWIDTH  plane width = height, sampled on accepted start.
- in_valid  input  1  pixel_in is valid this cycle.
- pixel_in  input  signed DWIDTH  raster-order pixel.
- win_valid  output  1  window holds a complete 5x5 neighbourhood.
- window  output  signed DWIDTH x 25 (unpacked [25-1:0])  window[5*i+j] = pixel(r-4+i, c-4+j).
- busy  output  1  high from accepted start until done.
- done  output  1  single-cycle pulse after the last window.
- err  output  1  single-cycle pulse on a rejected start.

Behaviour:
- Reset: asynchronous, active-low, effective immediately and mid-plane. FSM goes to IDLE. Counters, window registers and outputs go to 0: win_valid, busy, done, err, and all window elements. Line-buffer contents need not be cleared; they are never exposed before being overwritten.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start with 5 <= img_size <= MAXW latches the size into size$, clears row/col to 0, and goes to RUN. busy rises the next cycle.
  - IDLE: start with an illegal size raises err for 1 cycle (the cycle after start) and stays in IDLE.
  - IDLE: in_valid is ignored.
  - RUN: each in_valid cycle accepts 1 pixel. col increments; on col == size$-1, col wraps to 0 and row increments. No backpressure; gaps in in_valid are allowed and freeze all state.
  - RUN: accepting pixel (size$-1, size$-1) moves to FIN.
  - FIN: lasts 1 cycle. done = 1 and busy drops on that same edge. Returns to IDLE.
- start during RUN/FIN is ignored (no err).
- Line buffers: 4 rows x MAXW entries, addressed by col.
  - On accept, the column slice shifts upward: lb3[col] -> lb2, lb2 -> lb1, lb1 -> lb0 (oldest), pixel_in -> lb3.
  - A 5-entry column vector {lb0[col], lb1[col], lb2[col], lb3[col], pixel_in} shifts into the 5x5 window register from the right (column j=4). Existing columns shift left.
- Window output:
  - win_valid is registered, asserted the cycle after accepting pixel (r,c) with r >= 4 and c >= 4.
  - On all other cycles win_valid is low, including stall cycles; window then holds its last value.
  - Latency is exactly 1 cycle from the accepting edge.
  - Windows per plane: (size$-4)^2.
  - At column wrap, stale columns from the previous row occupy the window. They are not flagged valid until c reaches 4 again, so no window ever straddles rows.
- Back-to-back planes: start is accepted in IDLE only. The earliest new start is the cycle after done.
- Arithmetic: the block is pure data movement; no rounding or truncation. Counters are SWIDTH-bit unsigned and compared against size$-1.

Test Plan:
- Ramp plane: img_size=5, pixels 0..24 on consecutive cycles -> exactly 1 win_valid, 1 cycle after pixel 24, with window[k]=k for k=0..24. done follows 1 cycle later; busy low afterwards.
- 8x8 plane with pixel value 10*r+c -> 16 windows in raster order. The first has window[0]=0 and window[24]=44. The window at (r=7,c=5) has window[0]=31 and window[24]=75. No win_valid at c<4 of any row.
- Stalls: the 8x8 plane with in_valid toggled 1-0-1-0 -> same 16 windows and values. win_valid is never high in a cycle after an idle input cycle. done arrives 1 cycle after the last accept.
- Illegal size: start with img_size=4, then img_size=MAXW+1 -> err pulses each time; busy stays 0; in_valid pixels produce no win_valid.
- Reset mid-plane: after 30 pixels of an 8x8 plane, pulse xrst low asynchronously between edges -> outputs 0 immediately. A following 5x5 ramp plane yields a single correct window (window[k]=k).
- Start while busy: start with img_size=6 during an 8x8 plane -> ignored. The plane completes with 16 windows and err stays 0.
